game_state_manager: RTL and testbench



---
 rtl/game_state_manager_pkg.sv | 15 +
 rtl/game_state_manager_if.sv | 28 ++
 rtl/game_state_manager_frame_event_latch.sv | 36 +++
 rtl/game_state_manager.sv | 170 +++++++++++++++++
 tb/tb_game_state_manager.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/game_state_manager_pkg.sv
// Shared types for the game state manager: FSM state encoding and field widths.
package game_pkg;

  localparam int LIVES_W = 3;
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_PLAY      = 3'd1,
    ST_FREEZE    = 3'd2,
    ST_GAME_OVER = 3'd3,
    ST_WIN       = 3'd4
  } game_state_e;

endpackage

// File: rtl/game_state_manager_if.sv
// Frame/collision inputs and HUD/state outputs of the game state manager.
interface game_state_manager_if #(
  parameter int SCORE_W = 12,
  parameter int KILLS_W = 5
);
  logic                        startOfFrame;
  logic                        startGame;
  logic                        hitMonster;
  logic                        hitSpaceship;
  logic                        invasion;
  logic [SCORE_W-1:0]          score;
  logic [game_pkg::LIVES_W-1:0] lives;
  logic [KILLS_W-1:0]          kills;
  logic [game_pkg::STATE_W-1:0] state;
  logic                        playEnable;
  logic                        scorePulse;
  logic                        lifeLostPulse;

  modport master (
    output startOfFrame, startGame, hitMonster, hitSpaceship, invasion,
    input  score, lives, kills, state, playEnable, scorePulse, lifeLostPulse
  );

  modport slave (
    input  startOfFrame, startGame, hitMonster, hitSpaceship, invasion,
    output score, lives, kills, state, playEnable, scorePulse, lifeLostPulse
  );
endinterface

// File: rtl/game_state_manager_frame_event_latch.sv
// Sticky per-frame collision flag: set by event_in, reloaded on clear, forced low when disabled.
module frame_event_latch (
  input  logic clk,
  input  logic resetN,
  input  logic enable,
  input  logic clear,
  input  logic event_in,
  output logic flag
);

  logic flag_q;
  logic flag_d;

  // On the clear cycle the old frame is consumed, but a hit in that same cycle opens the next frame.
  always_comb begin
    flag_d = flag_q;
    if (!enable) begin
      flag_d = 1'b0;
    end else if (clear) begin
      flag_d = event_in;
    end else begin
      flag_d = flag_q | event_in;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      flag_q <= 1'b0;
    end else begin
      flag_q <= flag_d;
    end
  end

  assign flag = flag_q;

endmodule

// File: rtl/game_state_manager.sv
// Game state FSM: commits latched collisions once per frame into score, lives, kills and play state.
//   state        | meaning
//   ST_IDLE      | after reset, waiting for startGame
//   ST_PLAY      | objects moving, collisions latched and committed each frame
//   ST_FREEZE    | life just lost, field frozen for FREEZE_FRAMES frames
//   ST_GAME_OVER | lives exhausted or invasion, hold until startGame
//   ST_WIN       | all monsters killed, hold until startGame
module game_state_manager
  import game_pkg::*;
#(
  parameter int LIVES_INIT     = 3,
  parameter int SCORE_W        = 12,
  parameter int POINTS_PER_HIT = 10,
  parameter int FREEZE_FRAMES  = 60,
  parameter int MONSTERS_TOTAL = 24
) (
  input  logic                 clk,
  input  logic                 resetN,
  game_state_manager_if.slave  bus
);

  localparam int KILLS_W = $clog2(MONSTERS_TOTAL + 1);
  localparam int FRZ_W   = $clog2(FREEZE_FRAMES + 1);
  localparam logic [SCORE_W:0] SCORE_MAX = {1'b0, {SCORE_W{1'b1}}};

  game_state_e         state_q, state_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [LIVES_W-1:0]  lives_q, lives_d;
  logic [KILLS_W-1:0]  kills_q, kills_d;
  logic [FRZ_W-1:0]    frz_q, frz_d;
  logic                play_en_q, play_en_d;
  logic                score_pulse_q, score_pulse_d;
  logic                life_lost_q, life_lost_d;

  logic                flag_m, flag_s, flag_i;
  logic                latch_en;
  logic [SCORE_W:0]    score_sum;
  logic [SCORE_W-1:0]  score_sat;
  logic [KILLS_W-1:0]  kills_inc;

  // Flags only accumulate while play continues across the edge, so a hit in a
  // commit cycle that leaves PLAY never leaks into FREEZE or an end screen.
  assign latch_en = (state_q == ST_PLAY) && (state_d == ST_PLAY);

  frame_event_latch u_latch_m (
    .clk      (clk),
    .resetN   (resetN),
    .enable   (latch_en),
    .clear    (bus.startOfFrame),
    .event_in (bus.hitMonster),
    .flag     (flag_m)
  );

  frame_event_latch u_latch_s (
    .clk      (clk),
    .resetN   (resetN),
    .enable   (latch_en),
    .clear    (bus.startOfFrame),
    .event_in (bus.hitSpaceship),
    .flag     (flag_s)
  );

  frame_event_latch u_latch_i (
    .clk      (clk),
    .resetN   (resetN),
    .enable   (latch_en),
    .clear    (bus.startOfFrame),
    .event_in (bus.invasion),
    .flag     (flag_i)
  );

  assign score_sum = {1'b0, score_q} + (SCORE_W + 1)'(POINTS_PER_HIT);
  assign score_sat = (score_sum > SCORE_MAX) ? SCORE_MAX[SCORE_W-1:0] : score_sum[SCORE_W-1:0];
  assign kills_inc = kills_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    score_d       = score_q;
    lives_d       = lives_q;
    kills_d       = kills_q;
    frz_d         = frz_q;
    score_pulse_d = 1'b0;
    life_lost_d   = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_GAME_OVER, ST_WIN: begin
        if (bus.startGame) begin
          state_d = ST_PLAY;
          score_d = '0;
          lives_d = LIVES_W'(LIVES_INIT);
          kills_d = '0;
        end
      end

      ST_PLAY: begin
        if (bus.startOfFrame) begin
          if (flag_i) begin
            state_d = ST_GAME_OVER;
          end else begin
            if (flag_s) begin
              life_lost_d = 1'b1;
              lives_d     = lives_q - 1'b1;
              if (lives_q == LIVES_W'(1)) begin
                state_d = ST_GAME_OVER;
              end else begin
                state_d = ST_FREEZE;
                frz_d   = FRZ_W'(FREEZE_FRAMES);
              end
            end
            // Monster hits still score on the frame a life is lost; WIN yields only to GAME_OVER.
            if (flag_m) begin
              score_d       = score_sat;
              score_pulse_d = (score_sat != score_q);
              kills_d       = kills_inc;
              if (kills_inc == KILLS_W'(MONSTERS_TOTAL) && state_d != ST_GAME_OVER) begin
                state_d = ST_WIN;
              end
            end
          end
        end
      end

      ST_FREEZE: begin
        if (bus.startOfFrame && frz_q != '0) begin
          frz_d = frz_q - 1'b1;
          if (frz_q == FRZ_W'(1)) begin
            state_d = ST_PLAY;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    play_en_d = (state_d == ST_PLAY);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= ST_IDLE;
      score_q       <= '0;
      lives_q       <= LIVES_W'(LIVES_INIT);
      kills_q       <= '0;
      frz_q         <= '0;
      play_en_q     <= 1'b0;
      score_pulse_q <= 1'b0;
      life_lost_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      score_q       <= score_d;
      lives_q       <= lives_d;
      kills_q       <= kills_d;
      frz_q         <= frz_d;
      play_en_q     <= play_en_d;
      score_pulse_q <= score_pulse_d;
      life_lost_q   <= life_lost_d;
    end
  end

  assign bus.score         = score_q;
  assign bus.lives         = lives_q;
  assign bus.kills         = kills_q;
  assign bus.state         = state_q;
  assign bus.playEnable    = play_en_q;
  assign bus.scorePulse    = score_pulse_q;
  assign bus.lifeLostPulse = life_lost_q;

endmodule

// File: tb/tb_game_state_manager.sv
// Scoreboard bench for game_state_manager: a frame-level game model predicts every cycle's outputs.
module tb_game_state_manager;
  import game_pkg::*;

  localparam int SW  = 5;
  localparam int LI  = 3;
  localparam int PPH = 10;
  localparam int FF  = 60;
  localparam int MT  = 24;
  localparam int KW  = $clog2(MT + 1);

  localparam int S_IDLE = 0, S_PLAY = 1, S_FRZ = 2, S_GO = 3, S_WIN = 4;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  game_state_manager_if #(.SCORE_W(SW), .KILLS_W(KW)) bus ();

  game_state_manager #(
    .LIVES_INIT     (LI),
    .SCORE_W        (SW),
    .POINTS_PER_HIT (PPH),
    .FREEZE_FRAMES  (FF),
    .MONSTERS_TOTAL (MT)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  typedef struct packed {
    logic [2:0]    st;
    logic [SW-1:0] score;
    logic [2:0]    lives;
    logic [KW-1:0] kills;
    logic          pe;
    logic          sp;
    logic          lp;
  } exp_t;

  exp_t expq[$];
  int vectors = 0;
  int miscompares = 0;

  // Game model: whole-frame bookkeeping in plain integers.
  int m_st, m_score, m_lives, m_kills, m_frz;
  bit m_fm, m_fs, m_fi, m_sp, m_lp;

  function automatic void model_step(input bit rst_n, input bit sg, input bit sof,
                                     input bit hm, input bit hs, input bit inv);
    int nxt;
    int ns;
    m_sp = 0;
    m_lp = 0;
    if (!rst_n) begin
      m_st = S_IDLE; m_score = 0; m_lives = LI; m_kills = 0; m_frz = 0;
      m_fm = 0; m_fs = 0; m_fi = 0;
      return;
    end
    case (m_st)
      S_IDLE, S_GO, S_WIN: begin
        if (sg) begin
          m_st = S_PLAY; m_score = 0; m_lives = LI; m_kills = 0;
          m_fm = 0; m_fs = 0; m_fi = 0;
        end
      end
      S_PLAY: begin
        if (!sof) begin
          m_fm |= hm; m_fs |= hs; m_fi |= inv;
        end else begin
          nxt = S_PLAY;
          if (m_fi) begin
            nxt = S_GO;
          end else begin
            if (m_fs) begin
              m_lives = m_lives - 1;
              m_lp = 1;
              if (m_lives == 0) nxt = S_GO;
              else begin nxt = S_FRZ; m_frz = FF; end
            end
            if (m_fm) begin
              ns = m_score + PPH;
              if (ns > (1 << SW) - 1) ns = (1 << SW) - 1;
              m_sp = (ns != m_score);
              m_score = ns;
              m_kills = m_kills + 1;
              if (m_kills == MT && nxt != S_GO) nxt = S_WIN;
            end
          end
          m_st = nxt;
          if (nxt == S_PLAY) begin
            m_fm = hm; m_fs = hs; m_fi = inv;
          end else begin
            m_fm = 0; m_fs = 0; m_fi = 0;
          end
        end
      end
      S_FRZ: begin
        if (sof) begin
          m_frz = m_frz - 1;
          if (m_frz == 0) m_st = S_PLAY;
        end
      end
      default: m_st = S_IDLE;
    endcase
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.st    = 3'(m_st);
    e.score = SW'(m_score);
    e.lives = 3'(m_lives);
    e.kills = KW'(m_kills);
    e.pe    = (m_st == S_PLAY);
    e.sp    = m_sp;
    e.lp    = m_lp;
    return e;
  endfunction

  task automatic cyc(input bit rst_n, input bit sg, input bit sof,
                     input bit hm, input bit hs, input bit inv);
    @(negedge clk);
    resetN           = rst_n;
    bus.startGame    = sg;
    bus.startOfFrame = sof;
    bus.hitMonster   = hm;
    bus.hitSpaceship = hs;
    bus.invasion     = inv;
    model_step(rst_n, sg, sof, hm, hs, inv);
    expq.push_back(model_out());
  endtask

  function automatic bit pct(input int p);
    return ($urandom_range(99) < p);
  endfunction

  // len-1 ordinary cycles with random hits, then the startOfFrame cycle (no hits).
  task automatic frame(input int len, input int pm, input int ps, input int pi, input int psg);
    for (int i = 0; i < len - 1; i++)
      cyc(1, pct(psg), 0, pct(pm), pct(ps), pct(pi));
    cyc(1, 0, 1, 0, 0, 0);
  endtask

  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        a = {bus.state, bus.score, bus.lives, bus.kills,
             bus.playEnable, bus.scorePulse, bus.lifeLostPulse};
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL outputs t=%0t st/score/lives/kills/pe/sp/lp got %0d/%0d/%0d/%0d/%0b/%0b/%0b want %0d/%0d/%0d/%0d/%0b/%0b/%0b",
                   $time, a.st, a.score, a.lives, a.kills, a.pe, a.sp, a.lp,
                   e.st, e.score, e.lives, e.kills, e.pe, e.sp, e.lp);
        end
      end
    end
  end

  initial begin
    bus.startGame = 0; bus.startOfFrame = 0; bus.hitMonster = 0;
    bus.hitSpaceship = 0; bus.invasion = 0;
    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    repeat (2) cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    // long monster overlap in one frame counts once
    repeat (40) cyc(1, 0, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 0, 0);
    // spaceship and monster in the same frame, then the freeze with ignored hits/startGame
    cyc(1, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 1, 0);
    cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 1, 0, 1, 1, 1);
    for (int f = 0; f < FF; f++) frame(3, 50, 50, 30, 0);
    // down to game over via spaceship hits
    frame(4, 0, 100, 0, 0);
    for (int f = 0; f < FF; f++) frame(2, 0, 0, 0, 0);
    frame(4, 0, 100, 0, 0);
    frame(5, 50, 50, 50, 0);
    cyc(1, 1, 1, 0, 0, 0);
    // invasion beats a coincident monster hit
    cyc(1, 0, 0, 1, 0, 1);
    cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    // 24 monster frames to WIN, with score saturation on the way
    for (int f = 0; f < MT; f++) frame(3, 100, 0, 0, 0);
    frame(4, 100, 100, 100, 0);
    cyc(1, 1, 0, 0, 0, 0);
    // hit only in the commit cycle lands on the next frame
    cyc(1, 0, 1, 1, 0, 0);
    frame(3, 0, 0, 0, 0);
    // reset in the middle of a freeze
    frame(3, 0, 100, 0, 0);
    for (int f = 0; f < 5; f++) frame(2, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 1, 0);
    cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    // random play
    for (int f = 0; f < 300; f++)
      frame($urandom_range(2, 8), 25, 6, 2, 3);
    repeat (2) cyc(1, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    if (expq.size() != 0) begin
      miscompares++;
      $display("FAIL drain left=%0d want 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
